// File: rtl/stereolbm_axis_cambm_div_pkg.sv
// Shared types and constants for the stereo LBM depth divider.
// Holds the FSM encoding, the default operand widths and the iteration-counter width helper.
package stereolbm_axis_cambm_div_pkg;

  localparam int DEF_NUM_W = 32;
  localparam int DEF_DEN_W = 16;

  function automatic int cnt_width(input int num_w);
    return (num_w > 1) ? $clog2(num_w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_NUM_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/stereolbm_axis_cambm_div_step.sv
// One restoring-division step: shift in the next dividend bit, then compare-subtract.
// Purely combinational so an unrolled divider can chain several of these.
module stereolbm_axis_cambm_div_step #(
  parameter int DEN_W = 16
) (
  input  logic [DEN_W-1:0] partial_rem,
  input  logic             dividend_msb,
  input  logic [DEN_W-1:0] den,
  output logic [DEN_W-1:0] next_rem,
  output logic             qbit
);

  logic [DEN_W:0] trial;
  logic [DEN_W:0] diff;

  assign trial    = {partial_rem, dividend_msb};
  assign diff     = trial - {1'b0, den};
  assign qbit     = (trial >= {1'b0, den});
  // When the subtract succeeds the result is < den, so the top bit is always zero.
  assign next_rem = qbit ? diff[DEN_W-1:0] : trial[DEN_W-1:0];

endmodule

// File: rtl/stereolbm_axis_cambm_depth_div.sv
// Iterative radix-2 restoring divider: depth = product / disparity, one quotient bit per clock.
// Dividend and quotient share one shift register; valid/ready handshakes on both sides.
module stereolbm_axis_cambm_depth_div
  import stereolbm_axis_cambm_div_pkg::*;
#(
  parameter int ID    = 1,
  parameter int NUM_W = DEF_NUM_W,
  parameter int DEN_W = DEF_DEN_W
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NUM_W-1:0] in_num,
  input  logic [DEN_W-1:0] in_den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NUM_W-1:0] out_quot,
  output logic [DEN_W-1:0] out_rem,
  output logic             out_dz
);

  localparam int CW = cnt_width(NUM_W);

  state_t           state;
  state_t           state_n;
  logic [NUM_W-1:0] num_q;
  logic [DEN_W-1:0] den_q;
  logic [DEN_W-1:0] rem_q;
  logic [CW-1:0]    cnt;
  logic             dz_q;
  logic             vld_q;
  logic             accept;
  logic             handshake;
  logic [DEN_W-1:0] step_rem;
  logic             step_qbit;
  logic [31:0]      id_unused;

  assign id_unused = 32'(ID);

  stereolbm_axis_cambm_div_step #(
    .DEN_W (DEN_W)
  ) u_step (
    .partial_rem  (rem_q),
    .dividend_msb (num_q[NUM_W-1]),
    .den          (den_q),
    .next_rem     (step_rem),
    .qbit         (step_qbit)
  );

  assign accept    = in_valid && in_ready;
  assign handshake = vld_q && out_ready;

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = !ap_rst;
        if (in_valid && !ap_rst) begin
          state_n = (in_den == '0) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt == '0) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        if (vld_q && out_ready) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, handshake flag and datapath registers; everything is cleared by reset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= ST_IDLE;
      vld_q <= 1'b0;
      num_q <= '0;
      den_q <= '0;
      rem_q <= '0;
      cnt   <= '0;
      dz_q  <= 1'b0;
    end else begin
      state <= state_n;
      // out_valid trails entry to DONE by one edge and drops on the handshake edge.
      vld_q <= (state == ST_DONE) && !handshake;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            num_q <= (in_den == '0) ? '1 : in_num;
            den_q <= in_den;
            rem_q <= '0;
            cnt   <= CW'(NUM_W - 1);
            dz_q  <= (in_den == '0);
          end
        end
        ST_BUSY: begin
          num_q <= {num_q[NUM_W-2:0], step_qbit};
          rem_q <= step_rem;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = vld_q;
  assign out_quot  = num_q;
  assign out_rem   = rem_q;
  assign out_dz    = dz_q;

endmodule

// File: tb/tb_stereolbm_axis_cambm_depth_div.sv
// Self-checking bench for the depth divider: directed corner cases plus random operands
// compared against plain-arithmetic division.
module tb_stereolbm_axis_cambm_depth_div;

  localparam int NUM_W = 32;
  localparam int DEN_W = 16;

  logic             ap_clk = 1'b0;
  logic             ap_rst;
  logic             in_valid;
  logic             in_ready;
  logic [NUM_W-1:0] in_num;
  logic [DEN_W-1:0] in_den;
  logic             out_valid;
  logic             out_ready;
  logic [NUM_W-1:0] out_quot;
  logic [DEN_W-1:0] out_rem;
  logic             out_dz;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 ap_clk = ~ap_clk;

  stereolbm_axis_cambm_depth_div #(
    .ID    (1),
    .NUM_W (NUM_W),
    .DEN_W (DEN_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_num    (in_num),
    .in_den    (in_den),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_quot  (out_quot),
    .out_rem   (out_rem),
    .out_dz    (out_dz)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [NUM_W-1:0] ref_quot(input logic [NUM_W-1:0] n, input logic [DEN_W-1:0] d);
    longint unsigned nn = n;
    longint unsigned dd = d;
    if (d == 0) return '1;
    return NUM_W'(nn / dd);
  endfunction

  function automatic logic [DEN_W-1:0] ref_rem(input logic [NUM_W-1:0] n, input logic [DEN_W-1:0] d);
    longint unsigned nn = n;
    longint unsigned dd = d;
    if (d == 0) return '0;
    return DEN_W'(nn % dd);
  endfunction

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  // Present one pair, measure edges from accept to out_valid, check the result,
  // optionally stall the output, then complete the handshake.
  task automatic run_div(input string tag, input logic [NUM_W-1:0] n,
                         input logic [DEN_W-1:0] d, input int hold);
    int lat;
    check({tag, ".ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_num   = n;
    in_den   = d;
    step();
    in_valid = 1'b0;
    in_num   = $urandom;
    in_den   = DEN_W'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), (d == 0) ? 64'd1 : 64'(NUM_W + 1));
    check({tag, ".quot"}, 64'(out_quot), 64'(ref_quot(n, d)));
    check({tag, ".rem"}, 64'(out_rem), 64'(ref_rem(n, d)));
    check({tag, ".dz"}, 64'(out_dz), 64'(d == 0));
    repeat (hold) step();
    if (hold > 0) check({tag, ".held"}, 64'(out_quot), 64'(ref_quot(n, d)));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ".vld_clr"}, 64'(out_valid), 64'd0);
    check({tag, ".idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [NUM_W-1:0] rn;
    logic [DEN_W-1:0] rd;
    int               wait_cnt;
    bit               seen;

    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_num    = '0;
    in_den    = '0;
    repeat (3) step();
    check("rst.vld", 64'(out_valid), 64'd0);
    check("rst.quot", 64'(out_quot), 64'd0);
    check("rst.rem", 64'(out_rem), 64'd0);
    check("rst.dz", 64'(out_dz), 64'd0);
    check("rst.ready", 64'(in_ready), 64'd0);
    ap_rst = 1'b0;
    #1;
    check("rst.ready_after", 64'(in_ready), 64'd1);

    run_div("d1e6_7", 32'd1000000, 16'd7, 0);
    run_div("dmax", 32'hFFFE0001, 16'hFFFF, 2);
    run_div("lt", 32'd5, 16'd9, 0);
    run_div("zero", 32'd0, 16'd3, 1);
    run_div("dz", 32'd1234, 16'd0, 0);
    run_div("after_dz", 32'd1234, 16'd10, 0);

    // Backpressure with noise on the input side.
    in_valid = 1'b1;
    in_num   = 32'd1000;
    in_den   = 16'd13;
    step();
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 40) begin
      step();
      wait_cnt++;
    end
    check("bp.lat", 64'(wait_cnt), 64'(NUM_W + 1));
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      in_num   = $urandom;
      in_den   = DEN_W'($urandom);
      step();
      check("bp.vld", 64'(out_valid), 64'd1);
      check("bp.ready", 64'(in_ready), 64'd0);
      check("bp.quot", 64'(out_quot), 64'd76);
      check("bp.rem", 64'(out_rem), 64'd12);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp.vld_clr", 64'(out_valid), 64'd0);
    check("bp.idle", 64'(in_ready), 64'd1);
    step();
    check("bp.no_extra", 64'(in_ready), 64'd1);

    // Reset in the middle of an iteration sequence.
    in_valid = 1'b1;
    in_num   = 32'd100;
    in_den   = 16'd3;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    ap_rst = 1'b1;
    #1;
    check("mid.ready_in_rst", 64'(in_ready), 64'd0);
    step();
    ap_rst = 1'b0;
    #1;
    check("mid.ready", 64'(in_ready), 64'd1);
    check("mid.vld", 64'(out_valid), 64'd0);
    check("mid.quot", 64'(out_quot), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check("mid.no_output", 64'(seen), 64'd0);
    run_div("mid.fresh", 32'd100, 16'd3, 0);

    for (int i = 0; i < 25; i++) begin
      rn = $urandom;
      case ($urandom_range(0, 5))
        0:       rd = '0;
        1:       rd = DEN_W'($urandom_range(1, 15));
        2:       rd = 16'hFFFF;
        3:       begin rd = DEN_W'($urandom); rn = NUM_W'($urandom_range(0, 70000)); end
        default: rd = DEN_W'($urandom);
      endcase
      run_div($sformatf("rnd%0d", i), rn, rd, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not complete, got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
